dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data RAM (`mem`, combinational read, write on `clk` edge) between the core load/store port (port 0) and a debug/DMA loader port (port 1). It tracks ownership with a registered state machine, muxes the owner's request onto the RAM port, and registers read data into a one-cycle-delayed response. Ownership is round-robin with a burst limit so neither port starves. It sits between the core's data-memory signals and the `ram` instance.

---
 rtl/risc_pkg.sv | 20 ++
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: shared enums for the data-memory path and its arbiter
package risc_pkg;

   typedef enum logic [1:0] {
      DMEM_BYTE = 2'd0,
      DMEM_HALF = 2'd1,
      DMEM_WORD = 2'd2
   } op_enum_dmem_size;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } op_enum_arb_state;

   function automatic op_enum_arb_state own_state(input logic port);
      return port ? ARB_OWN1 : ARB_OWN0;
   endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin, burst-limited sharing of the data RAM between core and loader
module dmem_arbiter
   import risc_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int MAX_BURST  = 8
) (
   input  logic                  clk,
   input  logic                  res_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  wr0,
   input  logic                  wr1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  op_enum_dmem_size      size0,
   input  op_enum_dmem_size      size1,
   input  logic                  zero_ex0,
   input  logic                  zero_ex1,
   input  logic [31:0]           wr_data0,
   input  logic [31:0]           wr_data1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [31:0]           rd_data,
   output logic                  mem_req,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output op_enum_dmem_size      mem_size,
   output logic                  mem_zero_ex,
   output logic [31:0]           mem_wr_data,
   input  logic [31:0]           mem_rd_data
);

   localparam int BW = $clog2(MAX_BURST + 1);

   op_enum_arb_state owner;
   logic             last;
   logic [BW-1:0]    beats;
   logic             sel1;
   logic             cur_req;
   logic             oth_req;
   logic             burst_end;
   logic [BW-1:0]    beats_inc;

   assign sel1    = owner == ARB_OWN1;
   assign cur_req = sel1 ? req1 : req0;
   assign oth_req = sel1 ? req0 : req1;
   assign gnt0    = owner == ARB_OWN0 && req0;
   assign gnt1    = sel1 && req1;

   // A saturated count still forces a handover so a late requester cannot starve
   assign burst_end = (BW+1)'(beats) + 1'b1 >= (BW+1)'(MAX_BURST);
   assign beats_inc = beats == BW'(MAX_BURST) ? beats : beats + 1'b1;

   assign mem_req     = gnt0 | gnt1;
   assign mem_wen     = (gnt0 & wr0) | (gnt1 & wr1);
   assign mem_addr    = sel1 ? addr1 : addr0;
   assign mem_size    = sel1 ? size1 : size0;
   assign mem_zero_ex = sel1 ? zero_ex1 : zero_ex0;
   assign mem_wr_data = sel1 ? wr_data1 : wr_data0;

   // Ownership FSM: tie-break on last owner, hand over on release or burst limit
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         owner <= ARB_IDLE;
         last  <= 1'b1;
         beats <= '0;
      end else begin
         case (owner)
            ARB_IDLE: begin
               beats <= '0;
               if (req0 && (!req1 || last)) owner <= ARB_OWN0;
               else if (req1) owner <= ARB_OWN1;
            end
            ARB_OWN0, ARB_OWN1: begin
               if (!cur_req) begin
                  owner <= oth_req ? own_state(!sel1) : ARB_IDLE;
                  last  <= sel1;
                  beats <= '0;
               end else if (oth_req && burst_end) begin
                  owner <= own_state(!sel1);
                  last  <= sel1;
                  beats <= '0;
               end else begin
                  beats <= beats_inc;
               end
            end
            default: owner <= ARB_IDLE;
         endcase
      end
   end

   // Load response: capture RAM data on a granted load and flag the owning port next cycle
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rd_data <= '0;
      end else begin
         rvalid0 <= gnt0 & ~wr0;
         rvalid1 <= gnt1 & ~wr1;
         if ((gnt0 & ~wr0) | (gnt1 & ~wr1)) rd_data <= mem_rd_data;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a byte-addressed RAM model
module tb_dmem_arbiter;
   import risc_pkg::*;

   logic clk = 1'b0;
   logic res_n = 1'b0;
   always #5 clk = ~clk;

   logic req0, req1, wr0, wr1, zx0, zx1;
   logic [15:0] addr0, addr1;
   op_enum_dmem_size size0, size1;
   logic [31:0] wd0, wd1;
   logic gnt0, gnt1, rv0, rv1, mreq, mwen, mzx;
   logic [31:0] rd, mwd, mrd;
   logic [15:0] maddr;
   op_enum_dmem_size msize;

   logic b_req0, b_req1, b_gnt0, b_gnt1, b_rv0, b_rv1, b_mreq, b_mwen, b_mzx;
   logic [31:0] b_rd, b_mwd, b_mrd;
   logic [15:0] b_maddr;
   op_enum_dmem_size b_msize;

   dmem_arbiter #(.ADDR_WIDTH(16), .MAX_BURST(8)) dut_a (
      .clk(clk), .res_n(res_n), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .addr0(addr0), .addr1(addr1), .size0(size0), .size1(size1),
      .zero_ex0(zx0), .zero_ex1(zx1), .wr_data0(wd0), .wr_data1(wd1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rv0), .rvalid1(rv1), .rd_data(rd),
      .mem_req(mreq), .mem_wen(mwen), .mem_addr(maddr), .mem_size(msize),
      .mem_zero_ex(mzx), .mem_wr_data(mwd), .mem_rd_data(mrd)
   );

   dmem_arbiter #(.ADDR_WIDTH(16), .MAX_BURST(1)) dut_b (
      .clk(clk), .res_n(res_n), .req0(b_req0), .req1(b_req1), .wr0(1'b0), .wr1(1'b0),
      .addr0(16'h0100), .addr1(16'h0200), .size0(DMEM_WORD), .size1(DMEM_WORD),
      .zero_ex0(1'b0), .zero_ex1(1'b0), .wr_data0(32'h0), .wr_data1(32'h0),
      .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rv0), .rvalid1(b_rv1), .rd_data(b_rd),
      .mem_req(b_mreq), .mem_wen(b_mwen), .mem_addr(b_maddr), .mem_size(b_msize),
      .mem_zero_ex(b_mzx), .mem_wr_data(b_mwd), .mem_rd_data(b_mrd)
   );

   assign b_mrd = {16'h0000, b_maddr};

   // RAM model: combinational little-endian read with sign/zero extension, edge write
   logic [7:0] ram [256];
   logic [7:0] ra;
   logic [31:0] rw;
   always_comb begin
      ra = maddr[7:0];
      rw = {ram[ra+8'd3], ram[ra+8'd2], ram[ra+8'd1], ram[ra]};
      case (msize)
         DMEM_BYTE: mrd = {{24{~mzx & rw[7]}}, rw[7:0]};
         DMEM_HALF: mrd = {{16{~mzx & rw[15]}}, rw[15:0]};
         default:   mrd = rw;
      endcase
   end
   always @(posedge clk) begin
      if (mreq && mwen) begin
         ram[ra] <= mwd[7:0];
         if (msize != DMEM_BYTE) ram[ra+8'd1] <= mwd[15:8];
         if (msize == DMEM_WORD) begin
            ram[ra+8'd2] <= mwd[23:16];
            ram[ra+8'd3] <= mwd[31:24];
         end
      end
   end

   int checks = 0;
   int errors = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every load response must match the value queued when it was issued
   always @(negedge clk) begin
      if (res_n) begin
         if (rv0 || rv1) chk("rvalid_excl", 32'(rv0 & rv1), 32'h0);
         if (rv0) begin
            if (q0.size() > 0) chk("rd_data0", rd, q0.pop_front());
            else chk("rvalid0_spurious", 32'(rv0), 32'h0);
         end
         if (rv1) begin
            if (q1.size() > 0) chk("rd_data1", rd, q1.pop_front());
            else chk("rvalid1_spurious", 32'(rv1), 32'h0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      {req0, req1, wr0, wr1, zx0, zx1, b_req0, b_req1} = '0;
      addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
      size0 = DMEM_WORD; size1 = DMEM_WORD;
      repeat (2) step;
      chk("rst_outs", 32'({gnt0, gnt1, rv0, rv1, mreq, mwen, b_gnt0, b_gnt1, b_rv0, b_rv1}), 32'h0);
      chk("rst_rd_data", rd, 32'h0);
      chk("rst_owner", 32'(dut_a.owner), 32'(ARB_IDLE));
      res_n = 1'b1;
      // port 0: three back-to-back stores then a load
      step;
      req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0010; wd0 = 32'hDEADBEEF;
      #1 chk("a_idle_gnt0", 32'(gnt0), 32'h0);
      step;
      chk("a_st_gnt0", 32'(gnt0), 32'h1);
      chk("a_st_mem", 32'({mreq, mwen}), 32'h3);
      chk("a_st_addr", 32'(maddr), 32'h0010);
      step;
      addr0 = 16'h0020; wd0 = 32'h00000080;
      #1 chk("a_st2_gnt0", 32'(gnt0), 32'h1);
      step;
      addr0 = 16'h0030; wd0 = 32'h11223344;
      #1 chk("a_st3_gnt0", 32'(gnt0), 32'h1);
      step;
      wr0 = 1'b0; addr0 = 16'h0010; q0.push_back(32'hDEADBEEF);
      #1 chk("a_ld_gnt", 32'({gnt0, mwen}), 32'h2);
      step;
      req0 = 1'b0;
      #1 chk("a_ld_rvalid", 32'({rv0, rv1, gnt0}), 32'h4);
      step;
      chk("a_rvalid_once", 32'(rv0), 32'h0);
      // port 1: byte load sign- then zero-extended
      req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0020; size1 = DMEM_BYTE; zx1 = 1'b0;
      #1 chk("b_idle_gnt1", 32'(gnt1), 32'h0);
      step;
      chk("b_lb_gnt1", 32'({gnt0, gnt1}), 32'h1);
      chk("b_lb_size", 32'(msize), 32'(DMEM_BYTE));
      q1.push_back(32'hFFFFFF80);
      step;
      zx1 = 1'b1; q1.push_back(32'h00000080);
      #1 chk("b_lbu_gnt1", 32'(gnt1), 32'h1);
      step;
      req1 = 1'b0;
      #1 chk("b_rvalid1", 32'({rv0, rv1}), 32'h1);
      step;
      // both ports streaming stores: 8 beats each, no idle cycle at handover
      req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0050; size0 = DMEM_WORD; wd0 = 32'h55555555;
      req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0060; size1 = DMEM_WORD; wd1 = 32'h66666666;
      #1 chk("burst_idle", 32'({gnt0, gnt1}), 32'h0);
      for (int k = 0; k < 32; k++) begin
         step;
         chk($sformatf("burst%0d", k), 32'({gnt0, gnt1, mreq}), ((k / 8) % 2 == 0) ? 32'h5 : 32'h3);
      end
      step;
      chk("burst_wrap", 32'({gnt0, gnt1}), 32'h2);
      req0 = 1'b0; req1 = 1'b0;
      step;
      // port 1 keeps ownership while port 0 waits, then port 0 follows immediately
      req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0030; zx1 = 1'b0;
      #1 chk("c_idle", 32'(gnt1), 32'h0);
      step;
      chk("c_beat1", 32'({gnt0, gnt1}), 32'h1);
      q1.push_back(32'h11223344);
      step;
      req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0040; q1.push_back(32'h11223344);
      #1 chk("c_beat2", 32'({gnt0, gnt1}), 32'h1);
      step;
      q1.push_back(32'h11223344);
      #1 chk("c_beat3", 32'({gnt0, gnt1}), 32'h1);
      step;
      req1 = 1'b0;
      #1 chk("c_release", 32'({gnt0, gnt1}), 32'h0);
      step;
      chk("c_handover", 32'({gnt0, gnt1}), 32'h2);
      req0 = 1'b0;
      step;
      // reset in the middle of an OWN1 load drops its response
      req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0030;
      step;
      chk("e_gnt1", 32'(gnt1), 32'h1);
      res_n = 1'b0;
      #1 chk("e_async", 32'({gnt0, gnt1, mreq}), 32'h0);
      step;
      chk("e_outs", 32'({gnt0, gnt1, rv0, rv1, mreq, mwen}), 32'h0);
      chk("e_owner", 32'(dut_a.owner), 32'(ARB_IDLE));
      req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0070;
      res_n = 1'b1;
      step;
      chk("e_tie_port0", 32'({gnt0, gnt1}), 32'h2);
      req0 = 1'b0; req1 = 1'b0;
      step;
      // MAX_BURST = 1: strict alternation, responses follow the granted port
      b_req0 = 1'b1; b_req1 = 1'b1;
      #1 chk("alt_idle", 32'({b_gnt0, b_gnt1}), 32'h0);
      for (int k = 0; k < 8; k++) begin
         step;
         chk($sformatf("alt_gnt%0d", k), 32'({b_gnt0, b_gnt1}), (k % 2 == 0) ? 32'h2 : 32'h1);
         if (k > 0) begin
            chk($sformatf("alt_rv%0d", k), 32'({b_rv0, b_rv1}), (k % 2 == 1) ? 32'h2 : 32'h1);
            chk($sformatf("alt_rd%0d", k), b_rd, (k % 2 == 1) ? 32'h0100 : 32'h0200);
         end
      end
      b_req0 = 1'b0; b_req1 = 1'b0;
      repeat (2) step;
      chk("q0_drained", 32'(q0.size()), 32'h0);
      chk("q1_drained", 32'(q1.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
